// File: rtl/pc_gen_pkg.sv
// Shared constants and FSM encoding for the pc_gen program-counter generator.
package pc_gen_pkg;

  localparam logic RstEnable   = 1'b0;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic NoStop      = 1'b0;
  localparam logic Stop        = 1'b1;

  typedef enum logic [1:0] {
    PC_DISABLED = 2'd0,
    PC_ENABLE   = 2'd1,
    PC_RUN      = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_branch_buf.sv
// One-entry pending-branch buffer: holds a branch target resolved while fetch is stalled.
module pc_branch_buf
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] target_in,
  output logic              valid,
  output logic [ADDR_W-1:0] target
);

  // A new load always wins over clear so a newer branch replaces an older one.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      valid  <= 1'b0;
      target <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      target <= target_in;
    end else if (clear) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with flush redirect and pending-branch buffer.
// Optional target alignment check enabled by defining PC_ALIGN_CHECK_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                INST_BYTES   = 4,
  parameter int                STALL_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_address_i,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  new_pc_i,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               branch_pending_o,
  output logic               misalign_o
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_BYTES);

  pc_state_e         state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] tgt;
  logic              tgt_load;
  logic              buf_load, buf_clear, buf_valid;
  logic [ADDR_W-1:0] buf_target;
  logic              unused_stall;

  assign unused_stall = ^stall;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
    return a & ~ALIGN_MASK;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) misalign_o <= 1'b0;
    else                  misalign_o <= tgt_load && (|(tgt & ALIGN_MASK));
  end
`else
  assign misalign_o = 1'b0;
`endif

  pc_branch_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .clear     (buf_clear),
    .target_in (branch_target_address_i),
    .valid     (buf_valid),
    .target    (buf_target)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state <= PC_DISABLED;
      pc    <= RESET_VECTOR;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Priority: flush > stall (capturing any branch) > live branch > pending branch > increment.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    tgt       = pc;
    tgt_load  = 1'b0;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    case (state)
      PC_DISABLED: begin
        state_nxt = PC_ENABLE;
        pc_nxt    = RESET_VECTOR;
        buf_clear = 1'b1;
      end
      default: begin
        state_nxt = PC_RUN;
        if (flush_i) begin
          tgt       = new_pc_i;
          tgt_load  = 1'b1;
          buf_clear = 1'b1;
        end else if (stall[0] == Stop) begin
          buf_load  = branch_flag_i;
        end else if (branch_flag_i) begin
          tgt       = branch_target_address_i;
          tgt_load  = 1'b1;
          buf_clear = 1'b1;
        end else if (buf_valid) begin
          tgt       = buf_target;
          tgt_load  = 1'b1;
          buf_clear = 1'b1;
        end else begin
          pc_nxt    = pc + STEP;
        end
`ifdef PC_ALIGN_CHECK_EN
        if (tgt_load) pc_nxt = align_addr(tgt);
`else
        if (tgt_load) pc_nxt = tgt;
`endif
      end
    endcase
  end

  assign ce               = (state == PC_DISABLED) ? ChipDisable : ChipEnable;
  assign branch_pending_o = buf_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard testbench for pc_gen (RESET_VECTOR=BFC00000); honours PC_ALIGN_CHECK_EN.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'hBFC00000;

  typedef struct packed {
    logic [31:0] pc;
    logic        ce;
    logic        pend;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_address_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] new_pc_i = '0;
  logic [31:0] pc;
  logic        ce, branch_pending_o, misalign_o;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb_q[$];

  // Reference model state
  int          m_state = 0;
  logic [31:0] m_pc = RV;
  logic        m_pend = 1'b0;
  logic [31:0] m_ptgt = '0;
  logic        m_mis = 1'b0;

  pc_gen #(.ADDR_W(32), .RESET_VECTOR(RV), .INST_BYTES(4), .STALL_W(6)) u_dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .flush_i                 (flush_i),
    .new_pc_i                (new_pc_i),
    .pc                      (pc),
    .ce                      (ce),
    .branch_pending_o        (branch_pending_o),
    .misalign_o              (misalign_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = RV;
    m_pend  = 1'b0;
    m_ptgt  = '0;
    m_mis   = 1'b0;
  endtask

  task automatic model_edge(input logic s0, input logic br, input logic [31:0] bt,
                            input logic fl, input logic [31:0] np);
    logic        ld;
    logic [31:0] t;
    ld = 1'b0;
    t  = '0;
    if (m_state == 0) begin
      m_state = 1;
      m_pc    = RV;
      m_mis   = 1'b0;
    end else begin
      m_state = 2;
      if (fl) begin
        ld = 1'b1; t = np; m_pend = 1'b0;
      end else if (s0) begin
        if (br) begin m_pend = 1'b1; m_ptgt = bt; end
      end else if (br) begin
        ld = 1'b1; t = bt; m_pend = 1'b0;
      end else if (m_pend) begin
        ld = 1'b1; t = m_ptgt; m_pend = 1'b0;
      end else begin
        m_pc = m_pc + 32'd4;
      end
      m_mis = 1'b0;
      if (ld) begin
`ifdef PC_ALIGN_CHECK_EN
        m_pc  = {t[31:2], 2'b00};
        m_mis = |t[1:0];
`else
        m_pc  = t;
`endif
      end
    end
  endtask

  task automatic step(input string tag, input logic s0, input logic br, input logic [31:0] bt,
                      input logic fl, input logic [31:0] np);
    exp_t e;
    @(negedge clk);
    stall                   = {5'b0, s0};
    branch_flag_i           = br;
    branch_target_address_i = bt;
    flush_i                 = fl;
    new_pc_i                = np;
    model_edge(s0, br, bt, fl, np);
    sb_q.push_back('{pc: m_pc, ce: (m_state != 0), pend: m_pend, mis: m_mis});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_pc"},   pc,                      e.pc);
      check({tag, "_ce"},   {31'd0, ce},             {31'd0, e.ce});
      check({tag, "_pend"}, {31'd0, branch_pending_o}, {31'd0, e.pend});
      check({tag, "_mis"},  {31'd0, misalign_o},     {31'd0, e.mis});
    end
  endtask

  initial begin
    #2 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_pc",   pc,                        RV);
    check("rst_ce",   {31'd0, ce},               32'd0);
    check("rst_pend", {31'd0, branch_pending_o}, 32'd0);
    check("rst_mis",  {31'd0, misalign_o},       32'd0);
    rst = 1'b1;

    step("enable", 1'b0, 1'b0, '0, 1'b0, '0);
    step("seq1",   1'b0, 1'b0, '0, 1'b0, '0);
    step("seq2",   1'b0, 1'b0, '0, 1'b0, '0);

    // Branch during stall
    step("go100",   1'b0, 1'b0, '0, 1'b1, 32'h100);
    step("stbr",    1'b1, 1'b1, 32'h400, 1'b0, '0);
    step("st2",     1'b1, 1'b0, '0, 1'b0, '0);
    step("st3",     1'b1, 1'b0, '0, 1'b0, '0);
    step("rel400",  1'b0, 1'b0, '0, 1'b0, '0);
    step("seq404",  1'b0, 1'b0, '0, 1'b0, '0);

    // Flush overrides stall and drops pending branch
    step("stbr2",   1'b1, 1'b1, 32'h400, 1'b0, '0);
    step("flst",    1'b1, 1'b0, '0, 1'b1, 32'h80000180);
    step("relfl",   1'b0, 1'b0, '0, 1'b0, '0);

    // Flush and branch together
    step("flbr",    1'b0, 1'b1, 32'h300, 1'b1, 32'h200);

    // Live branch beats pending
    step("pend500", 1'b1, 1'b1, 32'h500, 1'b0, '0);
    step("live600", 1'b0, 1'b1, 32'h600, 1'b0, '0);
    step("seq604",  1'b0, 1'b0, '0, 1'b0, '0);

    // Newer pending overwrites older
    step("pend700", 1'b1, 1'b1, 32'h700, 1'b0, '0);
    step("pend800", 1'b1, 1'b1, 32'h800, 1'b0, '0);
    step("rel800",  1'b0, 1'b0, '0, 1'b0, '0);

    // Wrap-around
    step("gofffc",  1'b0, 1'b0, '0, 1'b1, 32'hFFFFFFFC);
    step("wrap",    1'b0, 1'b0, '0, 1'b0, '0);

    // Misaligned branch target
    step("br402",   1'b0, 1'b1, 32'h402, 1'b0, '0);
    step("aftmis",  1'b0, 1'b0, '0, 1'b0, '0);

    // Asynchronous reset with a pending branch
    step("pend900", 1'b1, 1'b1, 32'h900, 1'b0, '0);
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("arst_pc",   pc,                        RV);
    check("arst_ce",   {31'd0, ce},               32'd0);
    check("arst_pend", {31'd0, branch_pending_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("re_en",   1'b1, 1'b0, '0, 1'b0, '0);
    step("re_run",  1'b0, 1'b0, '0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
